// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg: shared encodings and defaults for the mips memory bus
package mips_bus_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam logic [3:0] BE_FULL = 4'hF;
endpackage

// File: rtl/mips_arb_starve_ctr.sv
// mips_arb_starve_ctr: counts back-to-back D grants while I waits and flags when I must win
module mips_arb_starve_ctr #(
  parameter int MAX_STREAK = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_gnt,
  input  logic i_gnt,
  input  logic i_req,
  output logic force_i
);
  localparam int W = $clog2(MAX_STREAK + 1);
  localparam logic [W-1:0] MAX = W'(MAX_STREAK);
  logic [W-1:0] streak;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) streak <= '0;
    else if (i_gnt | (d_gnt & ~i_req)) streak <= '0;
    else if (d_gnt) streak <= (streak == MAX) ? streak : streak + 1'b1;
  assign force_i = streak == MAX;
endmodule

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one memory port between fetch (I) and load/store (D), D first with starvation guard
module mips_mem_arbiter
  import mips_bus_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [3:0]        m_be,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_gnt,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);
  state_t state, state_nx;
  owner_t owner;
  logic we_q, force_i, pick_d, cap;
  logic [3:0] be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;

  mips_arb_starve_ctr #(.MAX_STREAK(MAX_STREAK)) u_ctr (
    .clk(clk), .rst_n(rst_n), .d_gnt(d_gnt), .i_gnt(i_gnt), .i_req(i_req), .force_i(force_i)
  );

  always_comb begin
    pick_d = d_req & ~(i_req & force_i);
    d_gnt = (state == IDLE) & pick_d;
    i_gnt = (state == IDLE) & i_req & ~pick_d;
    cap = ((state == REQ) & m_gnt & m_rvalid) | ((state == WAIT) & m_rvalid);
    state_nx = state;
    case (state)
      IDLE:    state_nx = (d_req | i_req) ? REQ : IDLE;
      REQ:     state_nx = m_gnt ? (m_rvalid ? RESP : WAIT) : REQ;
      WAIT:    state_nx = m_rvalid ? RESP : WAIT;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      owner   <= OWN_I;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nx;
      if (d_gnt | i_gnt) begin
        owner   <= d_gnt ? OWN_D : OWN_I;
        we_q    <= d_gnt & d_we;
        be_q    <= d_gnt ? d_be : BE_FULL;
        addr_q  <= d_gnt ? d_addr : i_addr;
        wdata_q <= d_gnt ? d_wdata : '0;
      end
      if (cap) rdata_q <= m_rdata;
    end

  assign busy     = state != IDLE;
  assign m_req    = state == REQ;
  assign m_we     = m_req & we_q;
  assign m_be     = m_req ? be_q : '0;
  assign m_addr   = m_req ? addr_q : '0;
  assign m_wdata  = m_req ? wdata_q : '0;
  assign i_rvalid = (state == RESP) & (owner == OWN_I);
  assign d_rvalid = (state == RESP) & (owner == OWN_D);
  // store acks carry no data back to the core
  assign i_rdata  = i_rvalid ? rdata_q : '0;
  assign d_rdata  = (d_rvalid & ~we_q) ? rdata_q : '0;
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb_mips_mem_arbiter: directed checks of arbitration, latency, starvation guard, stores and reset
module tb_mips_mem_arbiter;
  logic clk = 0, rst_n = 0;
  logic i_req = 0, i_gnt, i_rvalid;
  logic [31:0] i_addr = 0, i_rdata;
  logic d_req = 0, d_we = 0, d_gnt, d_rvalid;
  logic [3:0] d_be = 0;
  logic [31:0] d_addr = 0, d_wdata = 0, d_rdata;
  logic m_req, m_we, m_gnt, m_rvalid, busy;
  logic [3:0] m_be;
  logic [31:0] m_addr, m_wdata, m_rdata;
  int n_tests = 0, n_fail = 0;
  int gnt_dly = 0, rv_dly = 1, rv_cnt = 0, gcnt = 0, accepts = 0;
  logic [31:0] lat_addr = 0;

  always #5 clk = ~clk;

  mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STREAK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .busy(busy)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a == 32'h40 ? 32'h2402000F : a == 32'h100 ? 32'hDEADBEEF : (a ^ 32'hA5A50000);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_rv(input bit d, output logic [31:0] data, output bit seen);
    seen = 0;
    data = '0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (d ? d_rvalid : i_rvalid) begin
        seen = 1;
        data = d ? d_rdata : i_rdata;
      end
    end
  endtask

  task automatic wait_idle;
    for (int k = 0; k < 20 && busy; k++) @(negedge clk);
    chk("idle", busy, 0);
  endtask

  // memory model: grants after gnt_dly waiting cycles, answers rv_dly cycles after the grant
  initial begin
    m_gnt = 0; m_rvalid = 0; m_rdata = 0;
    forever begin
      @(posedge clk); #1;
      m_gnt = 0; m_rvalid = 0; m_rdata = '0;
      if (rv_cnt == 1) begin m_rvalid = 1; m_rdata = mem_word(lat_addr); end
      if (rv_cnt > 0) rv_cnt--;
      if (m_req) begin
        if (gcnt == gnt_dly) begin
          m_gnt = 1; gcnt = 0; accepts++; lat_addr = m_addr;
          if (rv_dly == 0) begin m_rvalid = 1; m_rdata = mem_word(m_addr); end
          else rv_cnt = rv_dly;
        end else gcnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    bit ok;
    int nd, both, cyc, bad, acc0, stray, junk;
    logic [5:0] ord;
    repeat (2) @(negedge clk);
    chk("rst_ctl", {i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, m_we, busy}, 0);
    chk("rst_data", i_rdata | d_rdata | m_addr | m_wdata, 0);
    chk("rst_be", m_be, 0);
    rst_n = 1;
    @(negedge clk);
    chk("idle_after_rst", {busy, i_gnt, d_gnt, m_req}, 0);
    // lone fetch, memory answers one cycle after the grant
    @(posedge clk); #1; i_req = 1; i_addr = 32'h40;
    @(negedge clk); chk("t2_i_gnt", i_gnt, 1); chk("t2_d_gnt", d_gnt, 0);
    @(posedge clk); #1; i_req = 0;
    @(negedge clk); chk("t2_m_req", m_req, 1); chk("t2_m_addr", m_addr, 32'h40); chk("t2_m_be", m_be, 4'hF);
    @(negedge clk); chk("t2_wait", {m_req, i_rvalid}, 0);
    @(negedge clk); chk("t2_i_rvalid", i_rvalid, 1); chk("t2_i_rdata", i_rdata, 32'h2402000F);
    chk("t2_d_rdata", d_rdata, 0); chk("t2_d_pulses", {d_gnt, d_rvalid}, 0);
    @(negedge clk); chk("t2_idle", {busy, i_rvalid}, 0);
    // simultaneous requests: D wins, I follows at the next idle cycle
    @(posedge clk); #1; i_req = 1; i_addr = 32'h200; d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h100;
    @(negedge clk); chk("t3_d_first", {d_gnt, i_gnt}, 2'b10);
    @(posedge clk); #1; d_req = 0;
    wait_rv(1, v, ok); chk("t3_d_seen", ok, 1); chk("t3_d_rdata", v, 32'hDEADBEEF);
    @(negedge clk); chk("t3_i_next", {d_gnt, i_gnt}, 2'b01);
    @(posedge clk); #1; i_req = 0;
    wait_rv(0, v, ok); chk("t3_i_rdata", v, 32'hA5A50200);
    wait_idle;
    // starvation guard with both requests held
    @(posedge clk); #1; i_req = 1; i_addr = 32'h300; d_req = 1; d_addr = 32'h400;
    nd = 0; both = 0; ord = '0;
    for (int k = 0; k < 100 && nd < 6; k++) begin
      @(negedge clk);
      if (i_gnt & d_gnt) both++;
      if (i_gnt | d_gnt) begin ord[5-nd] = d_gnt; nd++; end
    end
    @(posedge clk); #1; i_req = 0; d_req = 0;
    chk("t4_count", nd, 6); chk("t4_order", ord, 6'b111101); chk("t4_both", both, 0);
    wait_idle;
    // store with late memory grant
    gnt_dly = 2; acc0 = accepts;
    @(posedge clk); #1; d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'hFFF0; d_wdata = 32'h0F;
    @(negedge clk); chk("t5_d_gnt", d_gnt, 1);
    @(posedge clk); #1; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 32'hFFFFFFFF;
    cyc = 0; bad = 0; ok = 0; v = '1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (m_req) begin
        cyc++;
        if ({m_we, m_be, m_addr, m_wdata} !== {1'b1, 4'b0011, 32'hFFF0, 32'h0F}) bad++;
      end
      if (d_rvalid) begin ok = 1; v = d_rdata; end
    end
    chk("t5_mreq_cycles", cyc, 3); chk("t5_payload", bad, 0); chk("t5_seen", ok, 1);
    chk("t5_d_rdata", v, 0); chk("t5_accepts", accepts - acc0, 1);
    @(negedge clk); chk("t5_pulse", d_rvalid, 0);
    gnt_dly = 0;
    wait_idle;
    // reset while waiting on memory, then a stray response
    rv_dly = 6;
    @(posedge clk); #1; i_req = 1; i_addr = 32'h500; d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h600;
    @(negedge clk); chk("t6_d_gnt", d_gnt, 1);
    @(posedge clk); #1; i_req = 0; d_req = 0;
    @(negedge clk); chk("t6_req", m_req, 1);
    @(negedge clk); chk("t6_wait", {busy, m_req}, 2'b10); chk("t6_streak_pre", dut.u_ctr.streak, 1);
    #1 rst_n = 0;
    #2; chk("t6_rst_busy", busy, 0); chk("t6_streak", dut.u_ctr.streak, 0);
    @(negedge clk); rst_n = 1;
    stray = 0; junk = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      stray += int'(m_rvalid);
      junk += int'(i_rvalid | d_rvalid | busy);
    end
    chk("t6_stray_sent", stray, 1); chk("t6_no_resp", junk, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
